// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states
// and the request legality helpers used at accept time.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    RMW_RD = 3'd2,
    RMW_WR = 3'd3,
    WR     = 3'd4,
    RESP   = 3'd5
  } lsu_state_e;

  // Stores have no unsigned variants, so anything above SW is illegal.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) return (f3 > F3_W);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return (off != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends load data from a memory word
// and merges sub-word store data into the word read during read-modify-write.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[{i_off, 3'b000} +: 8];
    w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

    o_load = i_word;
    case (i_funct3)
      F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_load = {{16{w_half[15]}}, w_half};
      F3_BU:   o_load = {24'h0, w_byte};
      F3_HU:   o_load = {16'h0, w_half};
      default: o_load = i_word;
    endcase

    // Only the addressed lanes are replaced; the rest keep the fetched bytes.
    o_merged = i_word;
    case (i_funct3)
      F3_B:    o_merged[{i_off, 3'b000} +: 8]    = i_wdata[7:0];
      F3_H:    o_merged[{i_off[1], 4'b0000} +: 16] = i_wdata[15:0];
      default: o_merged = i_wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between the pipeline and a word-wide data memory with
// a combinational read port and a level-sensitive write port.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 2046
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_re,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output lsu_state_e  dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, and each request gets exactly one resp_valid pulse.
  lsu_state_e  r_state, w_next;
  logic        r_err, r_mem_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr, r_wdata, r_mem_wdata, r_rdata;
  logic        w_accept, w_err;
  logic [31:0] w_load, w_merged;

  assign w_accept = req_valid && req_ready;
  assign w_err    = f3_illegal(req_we, req_funct3) ||
                    misaligned(req_funct3, req_addr[1:0]) ||
                    ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));

  lsu_align u_align (
    .i_funct3 (r_funct3),
    .i_off    (r_addr[1:0]),
    .i_word   (mem_rdata),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_merged (w_merged)
  );

  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    mem_re     = 1'b0;
    resp_valid = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_err)                   w_next = RESP;
          else if (!req_we)            w_next = RD;
          else if (req_funct3 == F3_W) w_next = WR;
          else                         w_next = RMW_RD;
        end
      end
      RD:      begin mem_re = 1'b1; w_next = RESP; end
      RMW_RD:  begin mem_re = 1'b1; w_next = RMW_WR; end
      RMW_WR:  w_next = RESP;
      WR:      w_next = RESP;
      RESP:    begin resp_valid = 1'b1; w_next = IDLE; end
      default: w_next = IDLE;
    endcase
  end

  // Write strobe, address and data all come straight from flops so the
  // level-sensitive memory never sees a combinational glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_err       <= 1'b0;
      r_funct3    <= 3'b000;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= 32'h0;
      r_rdata     <= 32'h0;
    end else begin
      r_state  <= w_next;
      r_mem_we <= (w_next == WR) || (w_next == RMW_WR);
      if (w_accept) begin
        r_err    <= w_err;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        if (req_we) r_mem_wdata <= req_wdata;
      end
      if (r_state == RMW_RD) r_mem_wdata <= w_merged;
      if (r_state == RD)     r_rdata     <= w_load;
    end
  end

  assign mem_raddr  = {2'b00, r_addr[31:2]};
  assign mem_waddr  = {2'b00, r_addr[31:2]};
  assign mem_we     = r_mem_we;
  assign mem_wdata  = r_mem_wdata;
  assign resp_rdata = r_rdata;
  assign resp_err   = resp_valid && r_err;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: vector table of single requests, then
// reset-abort and back-to-back sequences, with a response scoreboard.
module tb_lsu_mem_ctrl;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        req_ready, resp_valid, resp_err, mem_re, mem_we;
  logic [31:0] resp_rdata, mem_raddr, mem_rdata, mem_waddr, mem_wdata;
  lsu_state_e  dbg_state;

  logic [31:0] mem [0:2047];

  lsu_mem_ctrl #(.MEM_WORDS(2046)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .dbg_state(dbg_state)
  );

  // clock / reset / memory model
  always #5 clk = ~clk;
  assign mem_rdata = (mem_raddr < 32'd2048) ? mem[mem_raddr[10:0]] : 32'h0;
  always @(posedge clk) if (mem_we && mem_waddr < 32'd2048) mem[mem_waddr[10:0]] <= mem_wdata;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  // scoreboard
  int tests = 0, fails = 0;
  logic [33:0] exp_q[$];  // {check_rdata, err, rdata}
  int re_cyc = 0, we_cyc = 0, viol = 0, resp_cnt = 0, acc_cnt = 0;
  logic [31:0] last_raddr = 32'h0, prev_waddr = 32'h0, prev_wdata = 32'h0;
  logic prev_we = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) if (rst_n && req_valid && req_ready) acc_cnt++;

  always @(negedge clk) begin
    logic [33:0] e;
    if (mem_re) begin re_cyc++; last_raddr = mem_raddr; end
    if (mem_we) we_cyc++;
    if (mem_re && mem_we) viol++;
    if (prev_we && (mem_waddr != prev_waddr || mem_wdata != prev_wdata)) viol++;
    prev_we = mem_we; prev_waddr = mem_waddr; prev_wdata = mem_wdata;
    if (resp_valid) begin
      resp_cnt++;
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected no response at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("resp_err", {31'h0, resp_err}, {31'h0, e[32]});
        if (e[33]) chk("resp_rdata", resp_rdata, e[31:0]);
      end
    end
  end

  // driver
  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          n_re;
    int          n_we;
    int          midx;
    logic [31:0] mval;
  } vec_t;

  task automatic run_req(input vec_t v);
    int lat;
    @(negedge clk); #1;
    re_cyc = 0; we_cyc = 0;
    chk("req_ready_idle", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    exp_q.push_back({(~v.we) | v.err, v.err, v.rdata});
    @(posedge clk); lat = 1; #1;
    req_valid = 1'b0;
    while (!resp_valid && lat < 10) begin @(posedge clk); lat++; #1; end
    chk("latency", 32'(lat), 32'(v.lat));
    @(posedge clk); #1;
    chk("resp_one_cycle", {31'h0, resp_valid}, 32'h0);
    chk("mem_re_cycles", 32'(re_cyc), 32'(v.n_re));
    chk("mem_we_cycles", 32'(we_cyc), 32'(v.n_we));
    chk("mem_word", mem[v.midx], v.mval);
  endtask

  vec_t vt[19];
  vec_t bb[4];
  vec_t one;

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    mem[5]    = 32'h8899AABB;
    mem[2045] = 32'hDEADBEEF;

    //          we    f3      addr        wdata         err   rdata          lat re we midx  mval
    vt[0]  = '{1'b0, 3'b000, 32'h15,   32'h0,        1'b0, 32'hFFFFFFAA, 2, 1, 0, 5,    32'h8899AABB};
    vt[1]  = '{1'b0, 3'b101, 32'h16,   32'h0,        1'b0, 32'h00008899, 2, 1, 0, 5,    32'h8899AABB};
    vt[2]  = '{1'b0, 3'b010, 32'h14,   32'h0,        1'b0, 32'h8899AABB, 2, 1, 0, 5,    32'h8899AABB};
    vt[3]  = '{1'b0, 3'b100, 32'h17,   32'h0,        1'b0, 32'h00000088, 2, 1, 0, 5,    32'h8899AABB};
    vt[4]  = '{1'b0, 3'b001, 32'h14,   32'h0,        1'b0, 32'hFFFFAABB, 2, 1, 0, 5,    32'h8899AABB};
    vt[5]  = '{1'b0, 3'b000, 32'h14,   32'h0,        1'b0, 32'hFFFFFFBB, 2, 1, 0, 5,    32'h8899AABB};
    vt[6]  = '{1'b0, 3'b101, 32'h14,   32'h0,        1'b0, 32'h0000AABB, 2, 1, 0, 5,    32'h8899AABB};
    vt[7]  = '{1'b0, 3'b010, 32'h16,   32'h0,        1'b1, 32'h0000AABB, 1, 0, 0, 5,    32'h8899AABB};
    vt[8]  = '{1'b1, 3'b010, 32'h1FF8, 32'h55555555, 1'b1, 32'h0000AABB, 1, 0, 0, 2046, 32'h0};
    vt[9]  = '{1'b0, 3'b001, 32'h15,   32'h0,        1'b1, 32'h0000AABB, 1, 0, 0, 5,    32'h8899AABB};
    vt[10] = '{1'b0, 3'b011, 32'h14,   32'h0,        1'b1, 32'h0000AABB, 1, 0, 0, 5,    32'h8899AABB};
    vt[11] = '{1'b1, 3'b011, 32'h14,   32'h12345678, 1'b1, 32'h0000AABB, 1, 0, 0, 5,    32'h8899AABB};
    vt[12] = '{1'b1, 3'b000, 32'h17,   32'h00000011, 1'b0, 32'h0,        3, 1, 1, 5,    32'h1199AABB};
    vt[13] = '{1'b1, 3'b001, 32'h14,   32'h0000CAFE, 1'b0, 32'h0,        3, 1, 1, 5,    32'h1199CAFE};
    vt[14] = '{1'b1, 3'b010, 32'h20,   32'h12345678, 1'b0, 32'h0,        2, 0, 1, 8,    32'h12345678};
    vt[15] = '{1'b0, 3'b010, 32'h20,   32'h0,        1'b0, 32'h12345678, 2, 1, 0, 8,    32'h12345678};
    vt[16] = '{1'b0, 3'b010, 32'h1FF4, 32'h0,        1'b0, 32'hDEADBEEF, 2, 1, 0, 2045, 32'hDEADBEEF};
    vt[17] = '{1'b0, 3'b000, 32'h1FF7, 32'h0,        1'b0, 32'hFFFFFFDE, 2, 1, 0, 2045, 32'hDEADBEEF};
    vt[18] = '{1'b1, 3'b100, 32'h20,   32'h0000FFFF, 1'b1, 32'hFFFFFFDE, 1, 0, 0, 8,    32'h12345678};

    bb[0]  = '{1'b0, 3'b010, 32'h14,   32'h0,        1'b0, 32'h1199CAFE, 0, 0, 0, 0,    32'h0};
    bb[1]  = '{1'b0, 3'b100, 32'h15,   32'h0,        1'b0, 32'h000000CA, 0, 0, 0, 0,    32'h0};
    bb[2]  = '{1'b1, 3'b000, 32'h20,   32'h00000077, 1'b0, 32'h0,        0, 0, 0, 0,    32'h0};
    bb[3]  = '{1'b0, 3'b010, 32'h20,   32'h0,        1'b0, 32'h12345677, 0, 0, 0, 0,    32'h0};

    // reset state, sampled without any clock edge relevance
    #12;
    chk("rst_req_ready",  {31'h0, req_ready},  32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_err",   {31'h0, resp_err},   32'h0);
    chk("rst_resp_rdata", resp_rdata,          32'h0);
    chk("rst_mem_re",     {31'h0, mem_re},     32'h0);
    chk("rst_mem_we",     {31'h0, mem_we},     32'h0);
    chk("rst_mem_raddr",  mem_raddr,           32'h0);
    chk("rst_mem_waddr",  mem_waddr,           32'h0);
    chk("rst_mem_wdata",  mem_wdata,           32'h0);
    chk("rst_state",      32'(dbg_state),      32'(IDLE));
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      run_req(vt[i]);
      if (i == 0) chk("lb_raddr", last_raddr, 32'd5);
    end

    // reset during RMW_RD of an SH: aborted, no response, word untouched
    @(negedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h20; req_wdata = 32'h0000BEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort_in_rmw_rd", 32'(dbg_state), 32'(RMW_RD));
    chk("abort_mem_re",    {31'h0, mem_re}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_rst_mem_re",    {31'h0, mem_re},     32'h0);
    chk("abort_rst_mem_we",    {31'h0, mem_we},     32'h0);
    chk("abort_rst_ready",     {31'h0, req_ready},  32'h1);
    chk("abort_rst_raddr",     mem_raddr,           32'h0);
    chk("abort_rst_resp_valid",{31'h0, resp_valid}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_word_kept", mem[8], 32'h12345678);
    one = '{1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'h12345678, 2, 1, 0, 8, 32'h12345678};
    run_req(one);

    // back-to-back with req_valid held high
    begin
      int a0, r0, n;
      a0 = acc_cnt; r0 = resp_cnt;
      @(negedge clk); #1;
      for (int k = 0; k < 4; k++) begin
        req_valid = 1'b1; req_we = bb[k].we; req_funct3 = bb[k].f3;
        req_addr = bb[k].addr; req_wdata = bb[k].wdata;
        n = 0;
        while (!req_ready && n < 10) begin @(posedge clk); #1; n++; end
        exp_q.push_back({~bb[k].we, 1'b0, bb[k].rdata});
        @(posedge clk); #1;
      end
      req_valid = 1'b0;
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin @(posedge clk); #1; n++; end
      repeat (2) @(negedge clk);
      chk("b2b_accepts",   32'(acc_cnt - a0),  32'd4);
      chk("b2b_responses", 32'(resp_cnt - r0), 32'd4);
      chk("b2b_drained",   32'(exp_q.size()),  32'd0);
      chk("b2b_sb_word",   mem[8],             32'h12345677);
    end

    chk("mem_port_protocol_violations", 32'(viol), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
